// File: rtl/rx_data_sampler.sv
// UART receiver data-recovery stage: 3-sample majority vote per bit, LSB-first
// deserialisation, parity/stop checking and one-cycle result strobes.
module rx_data_sampler #(
  parameter int DATA_WIDTH = 8,
  parameter int SAMPLE_MID = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  enable,
  input  logic [2:0]            edge_cnt,
  input  logic [3:0]            bit_cnt,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  sampled_bit
);

  localparam logic [2:0] EDGE_S0     = 3'(SAMPLE_MID - 1);
  localparam logic [2:0] EDGE_S1     = 3'(SAMPLE_MID);
  localparam logic [2:0] EDGE_S2     = 3'(SAMPLE_MID + 1);
  localparam logic [2:0] EDGE_DECIDE = 3'(SAMPLE_MID + 2);
  localparam logic [3:0] LAST_DATA   = 4'(DATA_WIDTH);
  localparam logic [3:0] PAR_IDX     = 4'(DATA_WIDTH + 1);
  localparam logic [3:0] STOP_NO_PAR = 4'(DATA_WIDTH + 1);
  localparam logic [3:0] STOP_PAR    = 4'(DATA_WIDTH + 2);

  typedef enum logic [2:0] {
    ROLE_NONE,
    ROLE_START,
    ROLE_DATA,
    ROLE_PARITY,
    ROLE_STOP
  } bit_role_t;

  logic                  s0, s1, s2;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_fail;
  logic                  vote;
  logic                  decide;
  logic                  parity_expected;
  bit_role_t             role;

  // Classify the current bit index; the stop index moves when parity is present.
  always_comb begin
    role            = ROLE_NONE;
    vote            = (s0 & s1) | (s0 & s2) | (s1 & s2);
    decide          = enable && (edge_cnt == EDGE_DECIDE);
    parity_expected = (^shift_reg) ^ PAR_TYP;
    if (bit_cnt == 4'd0)
      role = ROLE_START;
    else if (bit_cnt <= LAST_DATA)
      role = ROLE_DATA;
    else if (PAR_EN && (bit_cnt == PAR_IDX))
      role = ROLE_PARITY;
    else if (bit_cnt == (PAR_EN ? STOP_PAR : STOP_NO_PAR))
      role = ROLE_STOP;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      s0          <= 1'b0;
      s1          <= 1'b0;
      s2          <= 1'b0;
      shift_reg   <= '0;
      par_fail    <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      sampled_bit <= 1'b1;
    end else begin
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      if (!enable) begin
        s0        <= 1'b0;
        s1        <= 1'b0;
        s2        <= 1'b0;
        shift_reg <= '0;
        par_fail  <= 1'b0;
      end else begin
        if (edge_cnt == EDGE_S0) s0 <= RX_IN;
        if (edge_cnt == EDGE_S1) s1 <= RX_IN;
        if (edge_cnt == EDGE_S2) s2 <= RX_IN;
        if (decide) begin
          sampled_bit <= vote;
          // A frame that already failed parity must not publish its byte at the stop bit.
          case (role)
            ROLE_START:  if (vote) strt_glitch <= 1'b1;
            ROLE_DATA:   shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
            ROLE_PARITY: begin
              if (vote != parity_expected) begin
                par_err  <= 1'b1;
                par_fail <= 1'b1;
              end
            end
            ROLE_STOP: begin
              if (!vote) begin
                stp_err <= 1'b1;
              end else if (!par_fail) begin
                P_DATA     <= shift_reg;
                data_valid <= 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
